// File: rtl/mem_axi_bridge_pkg.sv
// mem_axi_bridge_pkg: shared definitions for the data-side and instruction-side
// AXI bridges.
//   bridge_state_t : FSM state encoding, common to both bridges
//   AXI_SIZE_*     : AxSIZE encodings for byte / half / word beats
//   AXI_BURST_INCR : burst type the bridges drive
//   DATA_AXI_ID    : AXI ID of the data side (instruction fetch uses 0)
//   RST_ENABLE     : active level of cpu_rst_n
//   ZERO_WORD      : 32-bit zero
package mem_axi_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WRITE = 3'd3,
    S_WRESP = 3'd4,
    S_DONE  = 3'd5
  } bridge_state_t;

  localparam logic [2:0]  AXI_SIZE_BYTE  = 3'd0;
  localparam logic [2:0]  AXI_SIZE_HALF  = 3'd1;
  localparam logic [2:0]  AXI_SIZE_WORD  = 3'd2;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [3:0]  DATA_AXI_ID    = 4'd1;
  localparam logic        RST_ENABLE     = 1'b0;
  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

  // AxSIZE for a MEM-stage access size (0 byte, 1 half, 2 word).
  function automatic logic [2:0] axi_size(input logic [1:0] mem_size);
    return {1'b0, mem_size};
  endfunction

endpackage

// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: data-side AXI master for the MEM stage. Each load or store
// becomes one single-beat AXI transaction; mem_stop_wb holds MEM/WB until the
// access completes, and drops for exactly one DONE cycle to let it capture.
//   cpu_clk_50M, cpu_rst_n           : clock, async active-low reset
//   mem_req/mem_wen/mem_size/mem_addr/mem_wdata : MEM stage request
//   flush                             : CP0 exception flush
//   mem_rdata, mem_stop_wb            : load result, MEM/WB stall
//   ar*/r*/aw*/w*/b*                  : AXI master channels
module mem_axi_bridge
  import mem_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = DATA_AXI_ID,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              mem_req,
  input  logic [3:0]        mem_wen,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              flush,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stop_wb,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  bridge_state_t state;
  logic          drop_q;
  logic          aw_done;
  logic          w_done;
  logic          aw_fin;
  logic          w_fin;

  // Response status and rlast carry no information for single-beat,
  // error-free transfers.
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp, rlast};

  // Single-beat transfers only.
  assign arid  = AXI_ID;
  assign awid  = AXI_ID;
  assign arlen = '0;
  assign awlen = '0;
  assign wlast = 1'b1;

  // Combinational so a new request stalls in the cycle it appears.
  assign mem_stop_wb = mem_req & ~flush & (state != S_DONE);

  // A channel counts as finished if it completed earlier or handshakes now;
  // this lets AW and W finish in either order or together.
  assign aw_fin = aw_done | (awvalid & awready);
  assign w_fin  = w_done  | (wvalid  & wready);

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (cpu_rst_n == RST_ENABLE) begin
      state     <= S_IDLE;
      drop_q    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      mem_rdata <= '0;
      araddr    <= '0;
      arsize    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      awsize    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          drop_q <= 1'b0;
          if (mem_req && !flush) begin
            if (mem_wen == '0) begin
              araddr  <= mem_addr;
              arsize  <= axi_size(mem_size);
              arvalid <= 1'b1;
              state   <= S_RADDR;
            end else begin
              awaddr  <= mem_addr;
              awsize  <= axi_size(mem_size);
              wdata   <= mem_wdata;
              wstrb   <= mem_wen;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= S_WRITE;
            end
          end
        end

        S_RADDR: begin
          if (flush) drop_q <= 1'b1;
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RDATA;
          end
        end

        S_RDATA: begin
          if (flush) drop_q <= 1'b1;
          if (rvalid) begin
            rready <= 1'b0;
            if (!drop_q) begin
              mem_rdata <= rdata;
              state     <= S_DONE;
            end else begin
              drop_q <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end

        S_WRITE: begin
          if (flush) drop_q <= 1'b1;
          if (awvalid && awready) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (wvalid && wready) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
            state   <= S_WRESP;
          end
        end

        S_WRESP: begin
          if (flush) drop_q <= 1'b1;
          if (bvalid) begin
            bready <= 1'b0;
            if (drop_q) begin
              drop_q <= 1'b0;
              state  <= S_IDLE;
            end else begin
              state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
